// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises three requesters onto one single-port synchronous RAM, one access per 4 cycles.
// Round-robin by default; define MEM_ARB_FIXED_PRIO_EN for fixed priority (device 0 > 1 > 2).
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [2:0]      i_dev_en,
  input  logic [2:0]      i_dev_we,
  input  logic [3*AW-1:0] i_dev_addr,
  input  logic [3*DW-1:0] i_dev_di,
  output logic [2:0]      o_dev_ack,
  output logic [DW-1:0]   o_dev_do,
  output logic            o_mem_en,
  output logic            o_mem_we,
  output logic [AW-1:0]   o_mem_addr,
  output logic [DW-1:0]   o_mem_di,
  input  logic [DW-1:0]   i_mem_do,
  output logic            o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_ACK} state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_grant, w_grant_nxt;
  logic            r_is_wr, w_is_wr_nxt;
  logic [2:0]      r_dev_ack, w_dev_ack_nxt;
  logic [DW-1:0]   r_dev_do, w_dev_do_nxt;
  logic            r_mem_en, w_mem_en_nxt;
  logic            r_mem_we, w_mem_we_nxt;
  logic [AW-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [DW-1:0]   r_mem_di, w_mem_di_nxt;
  logic            r_busy, w_busy_nxt;
  logic [1:0]      w_start;
  logic [1:0]      w_win;
  logic            w_any;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign w_start = 2'd0;
`else
  logic [1:0] r_ptr, w_ptr_nxt;

  assign w_start = r_ptr;

  // Pointer moves past the device just served so every other pending device goes first.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (r_state == S_ACK) w_ptr_nxt = (r_grant == 2'd2) ? 2'd0 : r_grant + 2'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_ptr <= 2'd0;
    else         r_ptr <= w_ptr_nxt;
  end
`endif

  // First requester at or above the start index, wrapping 2 -> 0.
  always_comb begin
    w_any = |i_dev_en;
    case (w_start)
      2'd1:    w_win = i_dev_en[1] ? 2'd1 : (i_dev_en[2] ? 2'd2 : 2'd0);
      2'd2:    w_win = i_dev_en[2] ? 2'd2 : (i_dev_en[0] ? 2'd0 : 2'd1);
      default: w_win = i_dev_en[0] ? 2'd0 : (i_dev_en[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_is_wr_nxt    = r_is_wr;
    w_dev_ack_nxt  = 3'b000;
    w_dev_do_nxt   = r_dev_do;
    w_mem_en_nxt   = r_mem_en;
    w_mem_we_nxt   = r_mem_we;
    w_mem_addr_nxt = r_mem_addr;
    w_mem_di_nxt   = r_mem_di;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant_nxt    = w_win;
          w_is_wr_nxt    = i_dev_we[w_win];
          w_mem_we_nxt   = i_dev_we[w_win];
          w_mem_addr_nxt = i_dev_addr[w_win*AW +: AW];
          w_mem_di_nxt   = i_dev_di[w_win*DW +: DW];
          w_mem_en_nxt   = 1'b1;
          w_state_nxt    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_mem_en_nxt = 1'b0;
        w_mem_we_nxt = 1'b0;
        w_state_nxt  = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (!r_is_wr) w_dev_do_nxt = i_mem_do;
        w_dev_ack_nxt = 3'b001 << r_grant;
        w_state_nxt   = S_ACK;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_grant    <= 2'd0;
      r_is_wr    <= 1'b0;
      r_dev_ack  <= 3'b000;
      r_dev_do   <= '0;
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_di   <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_is_wr    <= w_is_wr_nxt;
      r_dev_ack  <= w_dev_ack_nxt;
      r_dev_do   <= w_dev_do_nxt;
      r_mem_en   <= w_mem_en_nxt;
      r_mem_we   <= w_mem_we_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_mem_di   <= w_mem_di_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign o_dev_ack  = r_dev_ack;
  assign o_dev_do   = r_dev_do;
  assign o_mem_en   = r_mem_en;
  assign o_mem_we   = r_mem_we;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_di   = r_mem_di;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against an
// arithmetic model of the arbitration order, latency and RAM contents.
`timescale 1ns/1ps
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  en, we;
  logic [23:0] addr, di;
  logic [2:0]  ack;
  logic [7:0]  dout;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr, mem_di;
  logic [7:0]  mem_do = 8'h00;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] ref_mem [256];
  logic [7:0] ram [256];
  logic       ram_init = 1'b0;

  mem_arbiter #(.AW(8), .DW(8)) dut (
    .i_clk(clk), .i_reset(reset), .i_dev_en(en), .i_dev_we(we),
    .i_dev_addr(addr), .i_dev_di(di), .o_dev_ack(ack), .o_dev_do(dout),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_di(mem_di), .i_mem_do(mem_do), .o_busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int i);
    return (i == 5) ? 8'hA5 : 8'(i * 7 + 3);
  endfunction

  // Single-port synchronous RAM: read-before-write, data valid one edge after access.
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      ram_init <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_di;
      mem_do <= ram[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dev(input int d, input logic e, input logic w,
                         input logic [7:0] a, input logic [7:0] v);
    en[d] = e;
    we[d] = w;
    addr[d*8 +: 8] = a;
    di[d*8 +: 8] = v;
  endtask

  function automatic int pick(input logic [2:0] req, input int start);
    for (int k = 0; k < 3; k++)
      if (req[(start + k) % 3]) return (start + k) % 3;
    return -1;
  endfunction

  task automatic test_reset();
    logic [29:0] obs;
    reset = 1'b1;
    en = 3'b000;
    tick();
    tick();
    obs = {ack, dout, mem_en, mem_we, mem_addr, mem_di, busy};
    checks++;
    if (obs !== 30'd0) begin errors++; $display("FAIL reset_outputs: got %h want 0", obs); end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    set_dev(0, 1'b1, 1'b0, 8'h05, 8'h00);
    tick();
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 8'h05}) begin
      errors++; $display("FAIL rd_issue: got en=%b we=%b addr=%h want 1 0 05", mem_en, mem_we, mem_addr);
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy: got %b want 1", busy); end
    tick();
    checks++;
    if (mem_en !== 1'b0) begin errors++; $display("FAIL rd_en_clear: got %b want 0", mem_en); end
    tick();
    checks++;
    if (ack !== 3'b001) begin errors++; $display("FAIL rd_ack: got %b want 001", ack); end
    checks++;
    if (dout !== 8'hA5) begin errors++; $display("FAIL rd_data: got %h want a5", dout); end
    set_dev(0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    checks++;
    if ({ack, busy} !== 4'b0000) begin errors++; $display("FAIL rd_done: got ack=%b busy=%b want 000 0", ack, busy); end
  endtask

  task automatic test_write_readback();
    set_dev(1, 1'b1, 1'b1, 8'h10, 8'h3C);
    tick();
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_di} !== {1'b1, 1'b1, 8'h10, 8'h3C}) begin
      errors++; $display("FAIL wr_issue: got en=%b we=%b addr=%h di=%h want 1 1 10 3c", mem_en, mem_we, mem_addr, mem_di);
    end
    tick();
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL wr_we_one_cycle: got %b want 0", mem_we); end
    tick();
    checks++;
    if (ack !== 3'b010) begin errors++; $display("FAIL wr_ack: got %b want 010", ack); end
    checks++;
    if (dout !== 8'hA5) begin errors++; $display("FAIL wr_do_hold: got %h want a5", dout); end
    ref_mem[8'h10] = 8'h3C;
    set_dev(1, 1'b1, 1'b0, 8'h10, 8'h00);
    tick();
    checks++;
    if (mem_en !== 1'b0) begin errors++; $display("FAIL wb_gap: got mem_en=%b want 0", mem_en); end
    tick();
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 8'h10}) begin
      errors++; $display("FAIL wb_issue: got en=%b we=%b addr=%h want 1 0 10", mem_en, mem_we, mem_addr);
    end
    tick();
    tick();
    checks++;
    if ({ack, dout} !== {3'b010, 8'h3C}) begin
      errors++; $display("FAIL wb_ack: got ack=%b do=%h want 010 3c", ack, dout);
    end
    set_dev(1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
  endtask

  task automatic test_simultaneous();
    int exp;
    logic [2:0] ea;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int d = 0; d < 3; d++) set_dev(d, 1'b1, 1'b0, 8'(8'h20 + d), 8'h00);
    for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp = 0;
`else
      exp = k % 3;
`endif
      ea = 3'b001 << exp;
      tick();
      tick();
      tick();
      checks++;
      if ({ack, dout} !== {ea, ref_mem[8'h20 + exp]}) begin
        errors++; $display("FAIL simul_grant%0d: got ack=%b do=%h want %b %h", k, ack, dout, ea, ref_mem[8'h20 + exp]);
      end
      tick();
      checks++;
      if (ack !== 3'b000) begin errors++; $display("FAIL simul_pulse%0d: got %b want 000", k, ack); end
    end
    en = 3'b000;
    tick();
  endtask

  task automatic test_wrap();
    set_dev(2, 1'b1, 1'b0, 8'h30, 8'h00);
    tick();
    checks++;
    if ({mem_en, mem_addr} !== {1'b1, 8'h30}) begin errors++; $display("FAIL wrap_d2_issue: got %b %h want 1 30", mem_en, mem_addr); end
    tick();
    tick();
    checks++;
    if ({ack, dout} !== {3'b100, ref_mem[8'h30]}) begin errors++; $display("FAIL wrap_d2_ack: got %b %h want 100 %h", ack, dout, ref_mem[8'h30]); end
    set_dev(0, 1'b1, 1'b0, 8'h31, 8'h00);
    set_dev(2, 1'b1, 1'b0, 8'h32, 8'h00);
    tick();
    tick();
    checks++;
    if ({mem_en, mem_addr} !== {1'b1, 8'h31}) begin errors++; $display("FAIL wrap_d0_first: got %b %h want 1 31", mem_en, mem_addr); end
    tick();
    tick();
    checks++;
    if ({ack, dout} !== {3'b001, ref_mem[8'h31]}) begin errors++; $display("FAIL wrap_d0_ack: got %b %h want 001 %h", ack, dout, ref_mem[8'h31]); end
    set_dev(0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    checks++;
    if ({mem_en, mem_addr} !== {1'b1, 8'h32}) begin errors++; $display("FAIL wrap_d2_again: got %b %h want 1 32", mem_en, mem_addr); end
    tick();
    tick();
    checks++;
    if ({ack, dout} !== {3'b100, ref_mem[8'h32]}) begin errors++; $display("FAIL wrap_d2_ack2: got %b %h want 100 %h", ack, dout, ref_mem[8'h32]); end
    set_dev(2, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
  endtask

  task automatic test_reset_mid();
    logic [29:0] obs;
    set_dev(0, 1'b1, 1'b0, 8'h40, 8'h00);
    tick();
    tick();
    reset = 1'b1;
    tick();
    obs = {ack, dout, mem_en, mem_we, mem_addr, mem_di, busy};
    checks++;
    if (obs !== 30'd0) begin errors++; $display("FAIL rst_capture_clear: got %h want 0", obs); end
    set_dev(0, 1'b0, 1'b0, 8'h00, 8'h00);
    reset = 1'b0;
    tick();
    checks++;
    if (ack !== 3'b000) begin errors++; $display("FAIL rst_no_ack: got %b want 000", ack); end
    set_dev(0, 1'b1, 1'b0, 8'h41, 8'h00);
    tick();
    checks++;
    if ({mem_en, mem_addr} !== {1'b1, 8'h41}) begin errors++; $display("FAIL rst_after_issue: got %b %h want 1 41", mem_en, mem_addr); end
    tick();
    tick();
    checks++;
    if ({ack, dout} !== {3'b001, ref_mem[8'h41]}) begin errors++; $display("FAIL rst_after_ack: got %b %h want 001 %h", ack, dout, ref_mem[8'h41]); end
    set_dev(0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    // Write whose RAM edge coincides with reset must still land.
    set_dev(1, 1'b1, 1'b1, 8'h50, 8'h77);
    tick();
    reset = 1'b1;
    set_dev(1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    obs = {ack, dout, mem_en, mem_we, mem_addr, mem_di, busy};
    checks++;
    if (obs !== 30'd0) begin errors++; $display("FAIL rst_issue_clear: got %h want 0", obs); end
    reset = 1'b0;
    ref_mem[8'h50] = 8'h77;
    set_dev(1, 1'b1, 1'b0, 8'h50, 8'h00);
    tick();
    tick();
    tick();
    checks++;
    if ({ack, dout} !== {3'b010, 8'h77}) begin errors++; $display("FAIL rst_write_landed: got %b %h want 010 77", ack, dout); end
    set_dev(1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
  endtask

  task automatic test_drop_en();
    set_dev(1, 1'b1, 1'b1, 8'h60, 8'h99);
    tick();
    set_dev(1, 1'b0, 1'b0, 8'hFF, 8'h00);
    tick();
    tick();
    checks++;
    if ({ack, dout} !== {3'b010, 8'h77}) begin errors++; $display("FAIL drop_wr_ack: got %b %h want 010 77", ack, dout); end
    tick();
    ref_mem[8'h60] = 8'h99;
    set_dev(2, 1'b1, 1'b0, 8'h60, 8'h00);
    tick();
    set_dev(2, 1'b0, 1'b1, 8'hFF, 8'h00);
    tick();
    tick();
    checks++;
    if ({ack, dout} !== {3'b100, 8'h99}) begin errors++; $display("FAIL drop_rd_ack: got %b %h want 100 99", ack, dout); end
    tick();
  endtask

  task automatic test_random();
    int mptr, free_edge, ack_edge, g, gq, done_dev, start;
    logic [7:0] exp_data, m_do, a, v;
    logic [2:0] pend, ea;
    logic w;
    reset = 1'b1;
    en = 3'b000;
    tick();
    reset = 1'b0;
    mptr = 0; free_edge = 0; ack_edge = -10; gq = 0; done_dev = -1;
    m_do = 8'h00; exp_data = 8'h00; pend = 3'b000;
    for (int n = 0; n < 1500; n++) begin
      for (int d = 0; d < 3; d++) begin
        if (d == done_dev) pend[d] = 1'b0;
        if (!pend[d]) begin
          if ($urandom_range(0, 99) < ((d == done_dev) ? 50 : 30)) begin
            pend[d] = 1'b1;
            w = 1'($urandom_range(0, 1));
            a = 8'($urandom_range(0, 31));
            v = 8'($urandom_range(0, 255));
            set_dev(d, 1'b1, w, a, v);
          end else begin
            en[d] = 1'b0;
          end
        end
      end
      done_dev = -1;
`ifdef MEM_ARB_FIXED_PRIO_EN
      start = 0;
`else
      start = mptr;
`endif
      if (n >= free_edge && en != 3'b000) begin
        g = pick(en, start);
        gq = g;
        a = addr[g*8 +: 8];
        if (we[g]) begin
          exp_data = m_do;
          ref_mem[a] = di[g*8 +: 8];
        end else begin
          exp_data = ref_mem[a];
        end
        ack_edge = n + 2;
        free_edge = n + 4;
        mptr = (g + 1) % 3;
      end
      tick();
      ea = (n == ack_edge) ? (3'b001 << gq) : 3'b000;
      checks++;
      if (ack !== ea) begin errors++; $display("FAIL rand_ack@%0d: got %b want %b", n, ack, ea); end
      checks++;
      if (busy !== (n <= free_edge - 2)) begin errors++; $display("FAIL rand_busy@%0d: got %b want %b", n, busy, (n <= free_edge - 2)); end
      if (n == ack_edge) begin
        checks++;
        if (dout !== exp_data) begin errors++; $display("FAIL rand_data@%0d: got %h want %h", n, dout, exp_data); end
        m_do = exp_data;
        done_dev = gq;
      end
    end
    en = 3'b000;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    en = 3'b000; we = 3'b000; addr = 24'h0; di = 24'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    test_reset();
    test_single_read();
    test_write_readback();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    test_drop_en();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Round-robin arbiter that shares one single-port synchronous RAM between three requesting devices (instruction pipeline fetch port, plus two auxiliary masters).
- Sits between the device-side `en`/`ack` handshake buses and the RAM.
- Serialises accesses, drives the RAM address, data and write-enable, and returns read data with a one-cycle `ack` pulse to the granted device.

## Interface
- `AW`, 8, address width
- `DW`, 8, data width
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `dev_en`  in  3  per-device request; held high with stable addr/di/we until that device's ack
- `dev_we`  in  3  per-device write flag, sampled with `dev_en`
- `dev_addr`  in  3*AW  packed addresses, device i at [i*AW +: AW]
- `dev_di`  in  3*DW  packed write data, device i at [i*DW +: DW]
- `dev_ack`  out  3  one-cycle completion pulse, at most one bit set
- `dev_do`  out  DW  read data, valid while the granted `dev_ack` bit is high
- `mem_en`  out  1  RAM access strobe
- `mem_we`  out  1  RAM write enable
- `mem_addr`  out  AW  RAM address
- `mem_di`  out  DW  RAM write data
- `mem_do`  in  DW  RAM read data, valid one edge after the access edge
- `busy`  out  1  high in any state other than IDLE

## Operation
- All outputs are registered.
- Reset values:
  - `dev_ack`=0, `dev_do`=0
  - `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_di`=0
  - `busy`=0, state=IDLE, rr pointer=0, grant=0
- State machine, one transition per edge:
  - IDLE: if any `dev_en`, pick a winner and latch grant. Load `mem_addr`/`mem_di`/`mem_we` from the winner, set `mem_en`=1, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: the RAM performs the access at this edge. Clear `mem_en`/`mem_we`, go to CAPTURE.
  - CAPTURE:
    - Read: `dev_do`<=`mem_do`.
    - Write: `dev_do` holds its previous value.
    - Set `dev_ack[grant]`=1, go to ACK.
  - ACK: clear `dev_ack`, set rr pointer to (grant+1) mod 3, go to IDLE.
- Round-robin arbitration: search starts at the rr pointer and proceeds upward with wrap (pointer, pointer+1, pointer+2 mod 3). The first device with `dev_en` high wins.
- A device that keeps `en` high after its ack is treated as a new request. The pointer advance guarantees every other pending device is served first.
- `dev_en` changes during ISSUE/CAPTURE/ACK are ignored. The address and data were latched in IDLE.
- Index wrap: pointer value 3 never occurs, and grant+1 from 2 wraps to 0.

## Timing
- Edge E0: request sampled in IDLE.
- `mem_en` is high between E0 and E1, and the RAM acts at E1.
- `dev_ack`/`dev_do` are high between E2 and E3.
- IDLE is re-entered at E3, so the next grant is sampled at E4.
- Fixed throughput of one access per 4 cycles. Request-to-ack latency is 3 edges.
- Requester rule: drop `en` (or present the next request) on the edge where it sees `ack`.
- Simultaneous requests: exactly one is granted per IDLE visit. The others wait with `en` held.
- Reset mid-operation:
  - State returns to IDLE and all outputs clear at the reset edge. No ack is issued for the aborted access.
  - A write whose ISSUE edge coincides with the reset edge still reaches the RAM, because `mem_we` was already high before that edge.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority, device 0 > 1 > 2. The rr pointer is not implemented and the search always starts at 0. A continuously requesting device 0 can starve devices 1 and 2.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset then single read: RAM[0x05]=0xA5, device 0 requests read 0x05 at E0. Required: `mem_en`/`mem_addr`=0x05 at E0–E1, `dev_ack`=3'b001 and `dev_do`=0xA5 at E2–E3, `busy` low from E3.
- Write then read-back: device 1 writes 0x3C to 0x10, then reads 0x10. Required: `mem_we`=1 for exactly one cycle, `dev_do` unchanged on the write ack, `dev_do`=0x3C on the read ack, grants 4 cycles apart.
- Three simultaneous continuous requests starting from the reset pointer. Required grant order: 0,1,2,0,1,2. Each ack is one cycle and exactly one `dev_ack` bit is set. With `MEM_ARB_FIXED_PRIO_EN`, the order is 0,0,0… while device 0 holds `en`.
- Wrap-around: only device 2 requests, then devices 0 and 2 together. Required: after serving device 2 the pointer wraps to 0, so device 0 is granted before the next device 2 access.
- Reset asserted during CAPTURE of a read. Required: no `dev_ack` pulse, all outputs 0 the cycle after, and a request issued after reset deasserts is served normally with 3-edge latency.
- Requester drops `en` in ISSUE. Required: the access still completes and acks with the latched address and data.
